// File: rtl/sobel_frame_capture.sv
// sobel_frame_capture: captures the sobel_filter output stream into a frame buffer with a synchronous read port
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   arm                       one-cycle pulse that starts or restarts a capture
//   pixel_in, valid_in        filtered pixel stream
//   done_in                   end-of-frame indication from the filter
//   busy, capture_done        high while capturing / after a capture has ended
//   short_frame, overflow     sticky error flags
//   pixel_count               pixels written in the current or last capture
//   rd_en, rd_addr            read request and raster address
//   rd_data, rd_valid         read result, one cycle after rd_en
module sobel_frame_capture #(
    parameter int WIDTH = 8,
    parameter int IMG_WIDTH = 256,
    parameter int IMG_HEIGHT = 256,
    localparam int OUT_W = IMG_WIDTH - 2,
    localparam int OUT_H = IMG_HEIGHT - 2,
    localparam int DEPTH = OUT_W * OUT_H,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic [WIDTH-1:0]  pixel_in,
    input  logic              valid_in,
    input  logic              done_in,
    output logic              busy,
    output logic              capture_done,
    output logic              short_frame,
    output logic              overflow,
    output logic [ADDR_W:0]   pixel_count,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid
);
    localparam int COL_W = $clog2(OUT_W + 1);
    localparam int ROW_W = $clog2(OUT_H + 1);
    localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, CAPTURE, READY} state_t;

    state_t state, nxt;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [WIDTH-1:0] mem [DEPTH];
    logic wr, last, col_wrap;
    logic [ADDR_W-1:0] wr_addr;

    // A pixel arriving together with arm belongs to the abandoned capture
    assign wr = state == CAPTURE && valid_in && !arm;
    assign last = wr && pixel_count == FULL - 1'b1;
    assign col_wrap = col == COL_W'(OUT_W - 1);
    assign wr_addr = ADDR_W'(32'(row) * OUT_W + 32'(col));
    assign busy = state == CAPTURE;
    assign capture_done = state == READY;

    always_comb begin
        nxt = state;
        if (arm)
            nxt = CAPTURE;
        else if (state == CAPTURE && (last || done_in))
            nxt = READY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pixel_count <= '0;
            col <= '0;
            row <= '0;
            short_frame <= 1'b0;
            overflow <= 1'b0;
            rd_data <= '0;
            rd_valid <= 1'b0;
        end else begin
            state <= nxt;
            if (arm) begin
                pixel_count <= '0;
                col <= '0;
                row <= '0;
                short_frame <= 1'b0;
                overflow <= 1'b0;
            end else begin
                if (wr) begin
                    pixel_count <= pixel_count + 1'b1;
                    col <= col_wrap ? '0 : col + 1'b1;
                    row <= col_wrap ? row + 1'b1 : row;
                end
                // A frame completed by this very pixel is not short, even with done_in
                if (state == CAPTURE && done_in && !last)
                    short_frame <= 1'b1;
                if (state != CAPTURE && valid_in)
                    overflow <= 1'b1;
            end
            rd_valid <= rd_en;
            if (rd_en)
                rd_data <= ({1'b0, rd_addr} < FULL) ? mem[rd_addr] : '0;
        end
    end

    // Buffer contents survive reset and arm
    always_ff @(posedge clk) begin
        if (wr)
            mem[wr_addr] <= pixel_in;
    end
endmodule

// File: doc/sobel_frame_capture.md
# sobel_frame_capture

Receive-side companion to `sobel_filter`: accepts the filter's `pixel_out`/`valid_out`/`done` stream and writes the (IMG_WIDTH-2)×(IMG_HEIGHT-2) edge map into an internal frame buffer in raster order. A synchronous read port lets the host or a downstream writer fetch the captured frame. It replaces the bench-side collection loop with synthesizable logic and adds completion and error flags.

## Interface
- `WIDTH`, 8, pixel bit width
- `IMG_WIDTH`, 256, input image width; output width OUT_W = IMG_WIDTH-2
- `IMG_HEIGHT`, 256, input image height; output height OUT_H = IMG_HEIGHT-2
- `ADDR_W`, $clog2(OUT_W*OUT_H), buffer address width (derived, not overridden)

- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `arm`  in  1  one-cycle pulse: start or restart a capture
- `pixel_in`  in  WIDTH  filtered pixel (from `pixel_out`)
- `valid_in`  in  1  pixel qualifier (from `valid_out`)
- `done_in`  in  1  end-of-frame indication (from filter `done`)
- `busy`  out  1  high in CAPTURE
- `capture_done`  out  1  high in READY
- `short_frame`  out  1  sticky: `done_in` arrived before OUT_W*OUT_H pixels
- `overflow`  out  1  sticky: `valid_in` seen outside CAPTURE
- `pixel_count`  out  ADDR_W+1  pixels written in current/last capture
- `rd_en`  in  1  read request
- `rd_addr`  in  ADDR_W  raster address (row*OUT_W + col)
- `rd_data`  out  WIDTH  read data
- `rd_valid`  out  1  `rd_data` valid

## Operation
- States: IDLE, CAPTURE, READY. Reset -> IDLE.
- IDLE: `valid_in` not written; sets `overflow`. `arm` -> CAPTURE.
- On `arm` (any state): clear `pixel_count`, col/row counters, `short_frame`, `overflow`; enter CAPTURE. `valid_in` in the same cycle as `arm` is discarded and does not set `overflow`.
- CAPTURE: each `valid_in` writes `pixel_in` at address `pixel_count`, then increments it. Col counter 0..OUT_W-1 wraps to 0 and increments row; address always equals row*OUT_W+col.
- Pixel written when `pixel_count` = OUT_W*OUT_H-1 -> READY next cycle, `short_frame` stays 0 (even if `done_in` same cycle).
- `done_in` in CAPTURE without completing the frame -> READY, `short_frame`=1; a `valid_in` in that same cycle is still written first.
- `done_in` outside CAPTURE is ignored.
- READY: `valid_in` not written; sets `overflow`. Stays until `arm` or `rst`.
- Buffer: OUT_W*OUT_H × WIDTH, inferred single-write/single-read RAM, contents not cleared by reset or `arm`.
- Read port active in all states: `rd_en` with `rd_addr` < OUT_W*OUT_H returns stored word; address ≥ OUT_W*OUT_H returns 0. Read and write to same address in same cycle returns old data.
- `rst` mid-capture: immediate return to IDLE, flags and counts cleared, partial buffer contents retained.

## Timing
- Reset values: `busy`=0, `capture_done`=0, `short_frame`=0, `overflow`=0, `pixel_count`=0, `rd_data`=0, `rd_valid`=0.
- `arm` at edge N -> `busy`=1 after edge N; first acceptable pixel at edge N+1.
- Write: `valid_in` sampled at edge N -> word stored and `pixel_count` updated after edge N.
- Completion: last pixel at edge N -> `busy`=0, `capture_done`=1 after edge N.
- Read latency 1: `rd_en` at edge N -> `rd_data`/`rd_valid`=1 after edge N; `rd_valid`=0 the cycle after a non-read; `rd_data` holds last value.
- Full throughput: one pixel per clock, no backpressure.

## Test plan
- IMG_WIDTH=6, IMG_HEIGHT=5 (12 pixels); arm, stream values 1..12 back-to-back -> `capture_done`=1 one cycle after pixel 12, `pixel_count`=12, reads of addr 0..11 return 1..12, flags 0.
- Same, with gaps in `valid_in` and `done_in` coincident with pixel 12 -> identical buffer, `short_frame`=0.
- Stream 7 pixels then `done_in` -> READY, `short_frame`=1, `pixel_count`=7, addr 0..6 correct.
- In READY drive `valid_in` with 0xAA -> `overflow`=1, buffer unchanged; `arm` -> `overflow`=0, `busy`=1.
- `arm` after 5 pixels with `valid_in`=1 in the arm cycle -> that pixel dropped, counts restart at 0, next pixel lands at addr 0.
- `rst` after 4 pixels -> IDLE, all outputs at reset values; read addr 2 returns pre-reset data; read addr 12 returns 0.
